down_counter_timer: RTL and testbench
=====================================

Name: down_counter_timer

Overview:
- Loadable down-counter with a small control FSM. It is the count-down counterpart of the existing up-counter.
- It is loaded with a start value and decremented on `dec` strobes. It flags borrow-out at zero and issues a one-cycle `done` pulse on terminal count.
- It serves controllers that need "run N steps, then report", with optional auto-reload for periodic operation.

Parameters:
- SIZE, 10, width of the count register and of `init`.

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst  input  1  reset; one clock; reset is asynchronous and active-low.
- start  input  1  load `init` and begin counting; honoured only in IDLE or DONE.
- init  input  SIZE  start value, sampled on the accepted `start` cycle only.
- dec  input  1  decrement strobe; honoured only in RUN.
- auto_reload  input  1  when 1 at terminal count, reload `init` and stay in RUN.
- abort  input  1  stop counting; return to IDLE, holding `count`.
- count  output  SIZE  current register value.
- bo  output  1  borrow-out, combinational: 1 iff `count` == 0.
- busy  output  1  registered, 1 iff state == RUN.
- done  output  1  registered one-cycle pulse on terminal count.

Behaviour:
- Reset (rst=0, asynchronous): `count`=0, state=IDLE, `busy`=0, `done`=0. `bo`=1 as a consequence of `count`=0.
- States are IDLE, RUN and DONE.
- Priority each cycle: abort > start > dec. `done` defaults to 0 every cycle unless set below.
- IDLE:
  - start=1 and init != 0: `count`<=init, go to RUN.
  - start=1 and init == 0: `count`<=0, go to DONE, `done`<=1.
  - dec is ignored.
- RUN:
  - dec=1 and `count` > 1: `count`<=count-1.
  - dec=1 and `count` == 1, auto_reload=0: `count`<=0, go to DONE, `done`<=1.
  - dec=1 and `count` == 1, auto_reload=1: `count`<=init (init sampled that cycle), stay in RUN, `done`<=1.
  - If that reloaded init == 0: `count`<=0, go to DONE.
  - dec=0: hold.
  - start is ignored in RUN.
- DONE: `count` holds (normally 0). start behaves as in IDLE. dec is ignored.
- abort=1 in any state: go to IDLE next cycle, `count` holds, `done`<=0, even if dec or start is asserted the same cycle.
- Latency:
  - `count` updates 1 cycle after the qualifying strobe.
  - `done` and `busy` change in the same edge as the `count`/state update.
  - `bo` follows `count` combinationally (0 cycles).
- Decrement arithmetic: count + all-ones, modulo 2^SIZE. It is never applied at `count`=0, because RUN is never entered or held with `count`=0, so no wrap-around occurs.
- Back-to-back operation: start in the DONE cycle where `done`=1 is legal and restarts immediately.
- Reset mid-RUN: immediate return to IDLE with `count`=0. A pending `done` is cleared.

Decomposition:
- Shared package:
  - State encoding localparams ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2. 2'd3 is illegal and recovers to IDLE.
  - The COUNT_ONE compare constant.
- Sub-module dec_n #(SIZE):
  - Ripple decrementer built from existing fa cells with b=1'b1, cin=1'b0.
  - Outputs: difference, plus borrow (inverted final carry).
- The `count` register reuses n_bit_reg, with pen driven by the FSM.

Test Plan:
- Reset release, then start=1, init=3, then dec on 3 consecutive cycles → count 3,2,1,0; `done`=1 only in the cycle count becomes 0; state DONE; `busy` 1→0; `bo`=1.
- init=0 with start → next cycle count=0, `done`=1, `busy` never 1.
- auto_reload=1, init=2, 5 dec strobes → count 2,1,2,1,2,1; `done` pulses after strobes 2 and 4; `busy` stays 1.
- RUN with count=5, abort=1 and dec=1 in the same cycle → state IDLE, count=5, `done`=0; a following dec leaves count at 5.
- RUN with count=4: start=1, init=9 → ignored, count=4. In DONE: start=1, init=9 → count=9, `busy`=1.
- rst low asynchronously mid-RUN at count=7, between clock edges → count=0 and `busy`=0 immediately; `done` stays 0 after release.

Source files
------------

// File: rtl/down_counter_timer_pkg.sv
// Shared constants for the loadable down-counter timer: state encoding and
// the terminal-count compare value.
package down_counter_timer_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_RUN  = 2'd1;
  localparam state_t ST_DONE = 2'd2;

  // Sliced down to SIZE bits at the point of use.
  localparam logic [31:0] COUNT_ONE = 32'd1;

endpackage

// File: rtl/dec_n.sv
// Ripple decrementer: a + all-ones, built from fa cells.
// borrow is 1 only when a == 0 (no carry out of the top bit).
module dec_n #(
  parameter int SIZE = 10
) (
  input  logic [SIZE-1:0] a,
  output logic [SIZE-1:0] diff,
  output logic            borrow
);

  logic [SIZE:0] carry;

  assign carry[0] = 1'b0;

  for (genvar i = 0; i < SIZE; i++) begin : g_bit
    fa u_fa (
      .a    (a[i]),
      .b    (1'b1),
      .cin  (carry[i]),
      .s    (diff[i]),
      .cout (carry[i+1])
    );
  end

  assign borrow = ~carry[SIZE];

endmodule

// File: rtl/fa.sv
// One-bit full adder cell.
module fa (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/n_bit_reg.sv
// N-bit register with parallel-load enable and asynchronous active-low clear.
module n_bit_reg #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         pen,
  input  logic [N-1:0] d,
  output logic [N-1:0] q
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q <= '0;
    end else if (pen) begin
      q <= d;
    end
  end

endmodule

// File: rtl/down_counter_timer.sv
// Loadable down-counter with IDLE/RUN/DONE control, one-cycle done pulse on
// terminal count and optional auto-reload for periodic operation.
module down_counter_timer
  import down_counter_timer_pkg::*;
#(
  parameter int SIZE = 10
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [SIZE-1:0] init,
  input  logic            dec,
  input  logic            auto_reload,
  input  logic            abort,
  output logic [SIZE-1:0] count,
  output logic            bo,
  output logic            busy,
  output logic            done,
  output state_t          state
);

  // Strobes are level-sampled on each rising edge; there is no handshake.
  // Priority within a cycle is abort > start > dec.

  state_t          state_q;
  state_t          state_d;
  logic            done_d;
  logic            count_pen;
  logic [SIZE-1:0] count_d;
  logic [SIZE-1:0] dec_diff;
  logic            dec_borrow;
  logic            busy_q;
  logic            done_q;

  dec_n #(.SIZE(SIZE)) u_dec (
    .a      (count),
    .diff   (dec_diff),
    .borrow (dec_borrow)
  );

  n_bit_reg #(.N(SIZE)) u_count (
    .clk (clk),
    .rst (rst),
    .pen (count_pen),
    .d   (count_d),
    .q   (count)
  );

  always_comb begin
    state_d   = state_q;
    done_d    = 1'b0;
    count_pen = 1'b0;
    count_d   = count;
    if (abort) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            count_pen = 1'b1;
            count_d   = init;
            if (init != '0) begin
              state_d = ST_RUN;
            end else begin
              state_d = ST_DONE;
              done_d  = 1'b1;
            end
          end
        end
        ST_RUN: begin
          if (dec) begin
            count_pen = 1'b1;
            // A zero count in RUN is unreachable; it is folded into terminal.
            if (count == COUNT_ONE[SIZE-1:0] || dec_borrow) begin
              done_d = 1'b1;
              if (auto_reload && init != '0) begin
                count_d = init;
              end else begin
                count_d = '0;
                state_d = ST_DONE;
              end
            end else begin
              count_d = dec_diff;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= (state_d == ST_RUN);
      done_q  <= done_d;
    end
  end

  assign bo    = (count == '0);
  assign busy  = busy_q;
  assign done  = done_q;
  assign state = state_q;

endmodule

// File: tb/tb_down_counter_timer.sv
// Directed bench for down_counter_timer with hand-computed expectations.
module tb_down_counter_timer;

  localparam int SIZE = 10;

  logic            clk;
  logic            rst;
  logic            start;
  logic [SIZE-1:0] init;
  logic            dec;
  logic            auto_reload;
  logic            abort;
  logic [SIZE-1:0] count;
  logic            bo;
  logic            busy;
  logic            done;
  logic [1:0]      state;

  int pass_cnt = 0;
  int chk_cnt  = 0;

  down_counter_timer #(.SIZE(SIZE)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .init        (init),
    .dec         (dec),
    .auto_reload (auto_reload),
    .abort       (abort),
    .count       (count),
    .bo          (bo),
    .busy        (busy),
    .done        (done),
    .state       (state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // advance one clock and land on the falling edge for sampling/driving
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic expect_out(input string tag, input int c, input bit b, input bit d, input int st);
    check({tag, ".count"}, 32'(count), 32'(c));
    check({tag, ".busy"},  32'(busy),  32'(b));
    check({tag, ".done"},  32'(done),  32'(d));
    check({tag, ".state"}, 32'(state), 32'(st));
    check({tag, ".bo"},    32'(bo),    32'(c == 0));
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; init = '0; dec = 1'b0; auto_reload = 1'b0; abort = 1'b0;
    #12;
    expect_out("reset", 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b1;
    step();
    expect_out("post_rst", 0, 0, 0, 0);

    // init=3, three decrements
    start = 1'b1; init = 10'd3; step(); start = 1'b0;
    expect_out("t1_load", 3, 1, 0, 1);
    dec = 1'b1;
    step(); expect_out("t1_d1", 2, 1, 0, 1);
    step(); expect_out("t1_d2", 1, 1, 0, 1);
    step(); expect_out("t1_d3", 0, 0, 1, 2);
    step(); expect_out("t1_hold", 0, 0, 0, 2);
    dec = 1'b0;

    // init=0 goes straight to DONE
    start = 1'b1; init = 10'd0; step(); start = 1'b0;
    expect_out("t2_zero", 0, 0, 1, 2);
    step(); expect_out("t2_after", 0, 0, 0, 2);

    // auto-reload, init=2, five strobes
    auto_reload = 1'b1;
    start = 1'b1; init = 10'd2; step(); start = 1'b0;
    expect_out("t3_load", 2, 1, 0, 1);
    dec = 1'b1;
    step(); expect_out("t3_d1", 1, 1, 0, 1);
    step(); expect_out("t3_d2", 2, 1, 1, 1);
    step(); expect_out("t3_d3", 1, 1, 0, 1);
    step(); expect_out("t3_d4", 2, 1, 1, 1);
    step(); expect_out("t3_d5", 1, 1, 0, 1);
    // terminal with reload value zero falls to DONE
    init = 10'd0;
    step(); expect_out("t3_rl0", 0, 0, 1, 2);
    dec = 1'b0; auto_reload = 1'b0;

    // abort with dec in the same cycle
    start = 1'b1; init = 10'd5; step(); start = 1'b0;
    expect_out("t4_load", 5, 1, 0, 1);
    abort = 1'b1; dec = 1'b1; step(); abort = 1'b0;
    expect_out("t4_abort", 5, 0, 0, 0);
    step(); expect_out("t4_dec_idle", 5, 0, 0, 0);
    dec = 1'b0;

    // start ignored in RUN; back-to-back start in the done cycle
    start = 1'b1; init = 10'd4; step();
    expect_out("t5_load", 4, 1, 0, 1);
    init = 10'd9; step(); start = 1'b0;
    expect_out("t5_ignored", 4, 1, 0, 1);
    dec = 1'b1;
    step(); step(); step(); step();
    expect_out("t5_term", 0, 0, 1, 2);
    dec = 1'b0; start = 1'b1; init = 10'd9; step(); start = 1'b0;
    expect_out("t5_restart", 9, 1, 0, 1);

    // asynchronous reset between edges
    dec = 1'b1; step(); step(); dec = 1'b0;
    expect_out("t6_pre", 7, 1, 0, 1);
    #2 rst = 1'b0;
    #1 expect_out("t6_async", 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b1;
    step(); expect_out("t6_release", 0, 0, 0, 0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
